// File: rtl/instr_encoder_if.sv
// Field-bundle input and encoded-word output of the RV32I instruction encoder.
// Handshake rule for both channels: a transfer happens on a rising clk edge where valid && ready; once valid is raised with a payload, payload stays stable until that edge.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic        clr_cnt;
  logic [15:0] err_count;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output out_ready, clr_cnt,
    input  in_ready, out_valid, out_instr, out_err, err_count
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  out_ready, clr_cnt,
    output in_ready, out_valid, out_instr, out_err, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction encoder: registers decoded fields, packs them into a
// 32-bit word and flags immediates/opcodes the target format cannot represent.
package riscv_pkg;
  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_OP     = 7'b0110011
  } opcode_e;
endpackage

module instr_encoder
  import riscv_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  instr_encoder_if.slave bus
);

  logic        s1_valid;
  logic [6:0]  s1_opcode;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [2:0]  s1_funct3;
  logic [6:0]  s1_funct7;
  logic [31:0] s1_imm;

  logic        out_valid_q;
  logic [31:0] out_instr_q;
  logic        out_err_q;
  logic [15:0] err_count_q;

  logic        s2_adv;
  logic        in_fire;
  logic        out_fire;
  logic [31:0] enc_instr;
  logic        enc_err;
  logic        fits_i;
  logic        fits_b;
  logic        fits_j;
  logic        is_shift;

  assign s2_adv   = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_adv;
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = out_valid_q && bus.out_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_err   = out_err_q;
  assign bus.err_count = err_count_q;

  // Range checks as sign-extension tests: all bits above the field's sign bit must match it.
  assign fits_i   = (&s1_imm[31:11]) || !(|s1_imm[31:11]);
  assign fits_b   = ((&s1_imm[31:12]) || !(|s1_imm[31:12])) && !s1_imm[0];
  assign fits_j   = ((&s1_imm[31:20]) || !(|s1_imm[31:20])) && !s1_imm[0];
  assign is_shift = (s1_funct3 == 3'b001) || (s1_funct3 == 3'b101);

  always_comb begin
    enc_instr = '0;
    enc_err   = 1'b0;
    case (s1_opcode)
      OP_OP: begin
        enc_instr = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
      end
      OP_LOAD, OP_JALR: begin
        enc_instr = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
        enc_err   = !fits_i;
      end
      OP_IMM: begin
        if (is_shift) begin
          enc_instr = {s1_funct7, s1_imm[4:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
          enc_err   = |s1_imm[31:5];
        end else begin
          enc_instr = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
          enc_err   = !fits_i;
        end
      end
      OP_STORE: begin
        enc_instr = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
        enc_err   = !fits_i;
      end
      OP_BRANCH: begin
        enc_instr = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                     s1_imm[4:1], s1_imm[11], s1_opcode};
        enc_err   = !fits_b;
      end
      OP_LUI, OP_AUIPC: begin
        enc_instr = {s1_imm[31:12], s1_rd, s1_opcode};
        enc_err   = |s1_imm[11:0];
      end
      OP_JAL: begin
        enc_instr = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_opcode};
        enc_err   = !fits_j;
      end
      default: begin
        enc_instr = '0;
        enc_err   = 1'b1;
      end
    endcase
  end

  // Stage 1 reloads whenever it is free or draining into stage 2 this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_opcode <= '0;
      s1_rd     <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_funct3 <= '0;
      s1_funct7 <= '0;
      s1_imm    <= '0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (in_fire) begin
        s1_opcode <= bus.in_opcode;
        s1_rd     <= bus.in_rd;
        s1_rs1    <= bus.in_rs1;
        s1_rs2    <= bus.in_rs2;
        s1_funct3 <= bus.in_funct3;
        s1_funct7 <= bus.in_funct7;
        s1_imm    <= bus.in_imm;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_instr_q <= enc_instr;
        out_err_q   <= enc_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else if (bus.clr_cnt) begin
      err_count_q <= '0;
    end else if (out_fire && out_err_q && (err_count_q != 16'hFFFF)) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed steps plus random legal bundles, with a
// scoreboard that checks expected words and decodes every clean word back to its fields.
module tb_instr_encoder;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } bundle_t;

  typedef struct packed {
    bundle_t     b;
    logic        chk;
    logic [31:0] word;
    logic        err;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_encoder_if bus();
  instr_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  sb_t         exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bundle_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] imm);
    bundle_t b;
    b.op = op; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.f3 = f3; b.f7 = f7; b.imm = imm;
    return b;
  endfunction

  // Keep only the fields the opcode's format carries, so decode() output is comparable.
  function automatic bundle_t normalize(input bundle_t b);
    bundle_t n;
    n = '0;
    n.op = b.op;
    case (b.op)
      OPC_OP: begin n.rd = b.rd; n.rs1 = b.rs1; n.rs2 = b.rs2; n.f3 = b.f3; n.f7 = b.f7; end
      OPC_LOAD, OPC_JALR, OPC_OPIMM: begin
        n.rd = b.rd; n.rs1 = b.rs1; n.f3 = b.f3;
        if (b.op == OPC_OPIMM && (b.f3 == 3'b001 || b.f3 == 3'b101)) begin
          n.f7 = b.f7; n.imm = {27'b0, b.imm[4:0]};
        end else begin
          n.imm = b.imm;
        end
      end
      OPC_STORE, OPC_BRANCH: begin n.rs1 = b.rs1; n.rs2 = b.rs2; n.f3 = b.f3; n.imm = b.imm; end
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin n.rd = b.rd; n.imm = b.imm; end
      default: ;
    endcase
    return n;
  endfunction

  function automatic bundle_t decode(input logic [31:0] w);
    bundle_t d;
    d = '0;
    d.op = w[6:0];
    case (w[6:0])
      OPC_OP: begin d.rd = w[11:7]; d.f3 = w[14:12]; d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.f7 = w[31:25]; end
      OPC_LOAD, OPC_JALR, OPC_OPIMM: begin
        d.rd = w[11:7]; d.f3 = w[14:12]; d.rs1 = w[19:15];
        if (w[6:0] == OPC_OPIMM && (w[14:12] == 3'b001 || w[14:12] == 3'b101)) begin
          d.f7 = w[31:25]; d.imm = {27'b0, w[24:20]};
        end else begin
          d.imm = {{20{w[31]}}, w[31:20]};
        end
      end
      OPC_STORE: begin
        d.f3 = w[14:12]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
        d.imm = {{20{w[31]}}, w[31:25], w[11:7]};
      end
      OPC_BRANCH: begin
        d.f3 = w[14:12]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
        d.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin d.rd = w[11:7]; d.imm = {w[31:12], 12'b0}; end
      OPC_JAL: begin
        d.rd = w[11:7];
        d.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      end
      default: ;
    endcase
    return d;
  endfunction

  // Scoreboard: a word is consumed at the next rising edge iff valid && ready here.
  always @(negedge clk) begin
    sb_t e;
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $error("FAIL unexpected_word: observed %h expected none", bus.out_instr);
        end else begin
          e = exp_q.pop_front();
          if (e.chk) check("word", 64'(bus.out_instr), 64'(e.word));
          check("err", 64'(bus.out_err), 64'(e.err));
          if (!e.err) check("roundtrip", 64'(decode(bus.out_instr)), 64'(normalize(e.b)));
          if (e.err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
      end
      if (bus.clr_cnt) exp_cnt = '0;
    end
  end

  task automatic push(input bundle_t b, input logic chk, input logic [31:0] word,
                      input logic err, input logic rnd);
    sb_t e;
    bit  done;
    bit  hs;
    done = 1'b0;
    bus.in_opcode = b.op; bus.in_rd = b.rd; bus.in_rs1 = b.rs1; bus.in_rs2 = b.rs2;
    bus.in_funct3 = b.f3; bus.in_funct7 = b.f7; bus.in_imm = b.imm;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      hs = bus.in_ready;
      if (hs) begin
        e.b = b; e.chk = chk; e.word = word; e.err = err;
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
      if (hs) done = 1'b1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $error("FAIL push_timeout: observed in_ready 0 expected 1 within 200 cycles");
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bundle_t b;
    int      k;
    int      t;
    bit      seen;
    bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_imm = '0;
    bus.out_ready = 1'b1; bus.clr_cnt = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_instr", 64'(bus.out_instr), 64'(0));
    check("rst_out_err", 64'(bus.out_err), 64'(0));
    check("rst_err_count", 64'(bus.err_count), 64'(0));
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1;

    // ADDI x1, x2, -1 with two-cycle latency
    push(mk(OPC_OPIMM, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF), 1'b1, 32'hFFF10093, 1'b0, 1'b0);
    check("lat_n", 64'(bus.out_valid), 64'(0));
    @(posedge clk); #1;
    check("lat_n1", 64'(bus.out_valid), 64'(1));
    drain();

    // BEQ good and out-of-range
    push(mk(OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, -32'sd4), 1'b1, 32'hFE208EE3, 1'b0, 1'b0);
    push(mk(OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd4095), 1'b1, 32'h7E208FE3, 1'b1, 1'b0);
    drain();
    check("cnt_after_beq", 64'(bus.err_count), 64'(1));

    // Backpressure: third bundle stalls, first word holds
    bus.out_ready = 1'b0;
    push(mk(OPC_OPIMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1), 1'b1, 32'h00100093, 1'b0, 1'b0);
    push(mk(OPC_OPIMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2), 1'b1, 32'h00200093, 1'b0, 1'b0);
    bus.in_opcode = OPC_OPIMM; bus.in_rd = 5'd1; bus.in_rs1 = 5'd0; bus.in_funct3 = 3'b000;
    bus.in_imm = 32'd3; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("full_in_ready", 64'(bus.in_ready), 64'(0));
      check("hold_valid", 64'(bus.out_valid), 64'(1));
      check("hold_instr", 64'(bus.out_instr), 64'(32'h00100093));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    push(mk(OPC_OPIMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3), 1'b1, 32'h00300093, 1'b0, 1'b0);
    drain();

    // JAL and LUI, including a U immediate with low bits set
    push(mk(OPC_JAL, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048), 1'b1, 32'h001000EF, 1'b0, 1'b0);
    push(mk(OPC_LUI, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000), 1'b1, 32'h123452B7, 1'b0, 1'b0);
    push(mk(OPC_LUI, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345001), 1'b1, 32'h123452B7, 1'b1, 1'b0);
    drain();
    check("cnt_after_lui", 64'(bus.err_count), 64'(2));

    // Unknown opcode, with clr_cnt on the same cycle as its output handshake
    bus.out_ready = 1'b0;
    push(mk(7'h7F, 5'd3, 5'd4, 5'd5, 3'b010, 7'd9, 32'd77), 1'b1, 32'h0, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.out_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("unk_arrived", 64'(seen), 64'(1));
    bus.out_ready = 1'b1;
    bus.clr_cnt = 1'b1;
    @(posedge clk); #1;
    bus.clr_cnt = 1'b0;
    check("clr_priority", 64'(bus.err_count), 64'(0));
    check("clr_model", 64'(bus.err_count), 64'(exp_cnt));
    drain();

    // Asynchronous reset with both stages full
    push(mk(OPC_AUIPC, 5'd7, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00000800), 1'b1, 32'h00000397, 1'b1, 1'b0);
    drain();
    check("cnt_before_rst", 64'(bus.err_count), 64'(1));
    bus.out_ready = 1'b0;
    push(mk(OPC_OP, 5'd1, 5'd2, 5'd3, 3'b000, 7'h20, 32'd0), 1'b1, 32'h403100B3, 1'b0, 1'b0);
    push(mk(OPC_OP, 5'd4, 5'd5, 5'd6, 3'b111, 7'h00, 32'd0), 1'b1, 32'h0062F233, 1'b0, 1'b0);
    check("both_full", 64'(bus.in_ready), 64'(0));
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
    #1;
    check("rst_async_valid", 64'(bus.out_valid), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("post_rst_count", 64'(bus.err_count), 64'(0));
    @(posedge clk); #1;

    // Random legal bundles with random backpressure
    for (int n = 0; n < 1000; n++) begin
      k = $urandom_range(0, 9);
      b = mk(OPC_OP, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), $urandom);
      case (k)
        0: b.op = OPC_OP;
        1, 2, 4: begin
          b.op = (k == 1) ? OPC_LOAD : (k == 2) ? OPC_OPIMM : OPC_JALR;
          if (k == 2 && (b.f3 == 3'b001 || b.f3 == 3'b101)) b.f3 = 3'b000;
          t = int'($urandom_range(0, 4095)) - 2048; b.imm = 32'(t);
        end
        3: begin
          b.op = OPC_OPIMM; b.f3 = ($urandom_range(0, 1) != 0) ? 3'b001 : 3'b101;
          b.imm = 32'($urandom_range(0, 31));
        end
        5: begin b.op = OPC_STORE; t = int'($urandom_range(0, 4095)) - 2048; b.imm = 32'(t); end
        6: begin b.op = OPC_BRANCH; t = (int'($urandom_range(0, 4095)) - 2048) * 2; b.imm = 32'(t); end
        7: begin b.op = OPC_LUI; b.imm = {20'($urandom), 12'b0}; end
        8: begin b.op = OPC_AUIPC; b.imm = {20'($urandom), 12'b0}; end
        default: begin b.op = OPC_JAL; t = (int'($urandom_range(0, 1048575)) - 524288) * 2; b.imm = 32'(t); end
      endcase
      push(b, 1'b0, 32'h0, 1'b0, 1'b1);
    end
    drain();
    check("cnt_after_random", 64'(bus.err_count), 64'(exp_cnt));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
